ec_stripe_sequencer: RTL and testbench
======================================

# ec_stripe_sequencer

Parametrised control sequencer for the erasure-coding accelerator; the next generation of the engine control path. It replaces the single-row engine FSM with a multi-stripe, multi-pass scheduler. Each pass loads up to NUM_ENG bitmatrix rows into parallel engine slots, streams one stripe of data from the input-buffer FIFO, and drains NUM_ENG-wide parity packets into the output buffer. It sits between the control registers and the bitmatrix memory, input-buffer FIFO, engine array and output buffer.

## Interface
- K_MAX, 128, max data packets per stripe; K_MIN, 2, min
- M_MAX, 128, max parity rows; M_MIN, 2, min
- NUM_ENG, 4, parallel engine slots (parity rows per pass), power of 2
- PACKET_LENGTH, 2, words per packet
- STRIPE_W, 16, stripe counter width
- BM_ADDR_W, $clog2(M_MAX), bitmatrix row address width
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin job (pulse, sampled in IDLE only)
- abort  in  1  abandon job
- k_cfg  in  $clog2(K_MAX+1)  data packets per stripe, sampled on start
- m_cfg  in  $clog2(M_MAX+1)  parity rows, sampled on start
- num_stripes  in  STRIPE_W  stripes in job, sampled on start
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse, job complete
- cfg_err  out  1  one-cycle pulse, illegal k_cfg/m_cfg
- stripe_cnt  out  STRIPE_W  stripes completed in current job
- bm_rd_rq  out  1  bitmatrix row read request (pulse)
- bm_rd_addr  out  BM_ADDR_W  row address
- bm_rd_val  in  1  row data valid (any latency ≥1)
- eng_bm_load  out  1  load current row into slot eng_bm_slot
- eng_bm_slot  out  $clog2(NUM_ENG)  target slot
- eng_row_mask  out  NUM_ENG  slots active this pass
- eng_rst  out  1  engine array synchronous clear (pulse)
- inbuf_empty  in  1  input FIFO empty
- inbuf_rd_rq  out  1  FIFO pop
- inbuf_rewind  out  1  pulse, rewind FIFO read pointer to stripe start
- inbuf_release  out  1  pulse, free current stripe in FIFO
- eng_in_rdy  in  1  engine accepts data
- eng_in_val  out  1  data word valid to engine
- eng_out_val  in  1  engine parity word valid
- eng_out_rdy  out  1  sequencer accepts parity word
- outbuf_full  in  1  output buffer full
- outbuf_wr_en  out  1  output buffer write

## Operation
- States: IDLE, CHECK, FETCH, BM_WAIT, FEED, WRITE, NEXT.
- IDLE: start latches cfg and clears stripe_cnt, pass, slot → CHECK.
- CHECK: k_cfg outside [K_MIN,K_MAX] or m_cfg outside [M_MIN,M_MAX] → cfg_err, IDLE. num_stripes==0 → done, IDLE. Else eng_rst pulse → FETCH.
- FETCH: bm_rd_rq=1, bm_rd_addr=pass*NUM_ENG+slot → BM_WAIT. One outstanding request only.
- BM_WAIT: eng_bm_load = bm_rd_val (combinational); on val: slot++.
  - If slot is last, or row+1==m_cfg → FEED.
  - Else → FETCH.
- eng_row_mask: bit i set when pass*NUM_ENG+i < m_cfg; registered at FETCH of slot 0.
- FEED: inbuf_rd_rq = !inbuf_empty && eng_in_rdy; eng_in_val = inbuf_rd_rq delayed 1 cycle (FIFO read latency 1). After k_cfg*PACKET_LENGTH pops and the final eng_in_val → WRITE.
- WRITE: eng_out_rdy = !outbuf_full; outbuf_wr_en = eng_out_val && !outbuf_full. After popcount(eng_row_mask)*PACKET_LENGTH writes → NEXT.
- NEXT:
  - More passes (next row < m_cfg): inbuf_rewind pulse, pass++, slot=0, eng_rst → FETCH.
  - Else: inbuf_release pulse, stripe_cnt++, pass=0.
    - If stripe_cnt+1==num_stripes → done, IDLE.
    - Else eng_rst → FETCH.
- abort in any non-IDLE state: next cycle IDLE, eng_rst pulse, all request strobes low. Pending bm_rd_val is ignored. No done, no release.
- start while busy is ignored. Simultaneous start and abort in IDLE: start wins; abort has no effect in IDLE.
- Counters use full width. Word count width is $clog2(K_MAX*PACKET_LENGTH+1). stripe_cnt does not wrap within a job.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0.
- start → busy at next edge. cfg_err/done from CHECK appear 2 cycles after start.
- bm_rd_rq asserts 1 cycle after entering FETCH. eng_bm_load is coincident with bm_rd_val.
- FEED throughput is 1 word/cycle with no stalls. Stalls come only from inbuf_empty or !eng_in_rdy.
- WRITE throughput is 1 word/cycle. outbuf_full stalls with no word loss (eng_out_val held by engine).
- Strobes eng_rst, inbuf_rewind, inbuf_release, done and cfg_err are exactly one cycle.
- rst is asynchronous: outputs clear immediately. State is IDLE on the first clk after deassertion.

## Test plan
- k=4, m=4, NUM_ENG=4, 1 stripe, no stalls → 4 bm reads (addr 0..3), 8 pops, 8 writes, no rewind, 1 release, done; stripe_cnt=1.
- k=3, m=6, 2 stripes → per stripe: pass0 mask 1111, pass1 mask 0011. 6 pops per pass, 1 rewind per stripe, writes 8+4 per stripe. Job ends with done and stripe_cnt=2.
- k=1 or m=129 → cfg_err 2 cycles after start, no bm_rd_rq; num_stripes=0 → done, no other strobes.
- Random inbuf_empty, eng_in_rdy and outbuf_full toggling at k=2, m=2 → exactly 4 pops, 4 writes, no outbuf_wr_en while full.
- abort mid-FEED → IDLE next cycle, eng_rst pulse, busy=0, no done/release; a new start then runs to completion.
- rst asserted mid-WRITE → all outputs 0 immediately; after release, start runs a clean job.

Source files
------------

// File: rtl/ec_stripe_sequencer.sv
// ec_stripe_sequencer
//   Control sequencer for the erasure-coding engine array. A job runs
//   num_stripes stripes. Each stripe takes ceil(m/NUM_ENG) passes. A pass
//   works in three steps:
//     - load up to NUM_ENG bitmatrix rows into the engine slots;
//     - stream k*PACKET_LENGTH words from the input FIFO into the engines;
//     - drain the parity words of the active slots into the output buffer.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   start, abort         job start (sampled in IDLE), job abandon
//   k_cfg, m_cfg,        job configuration, latched on start
//     num_stripes
//   busy, done, cfg_err  status; done and cfg_err are one-cycle pulses
//   stripe_cnt           stripes completed in the current job
//   bm_rd_*              bitmatrix row read (one outstanding request)
//   eng_bm_load/slot     row load into an engine slot
//   eng_row_mask         engine slots active in the current pass
//   eng_rst              engine array clear pulse
//   inbuf_*              input FIFO pop / rewind / release
//   eng_in_*, eng_out_*  engine data-in and parity-out handshakes
//   outbuf_*             output buffer write
module ec_stripe_sequencer #(
    parameter int K_MAX         = 128,
    parameter int K_MIN         = 2,
    parameter int M_MAX         = 128,
    parameter int M_MIN         = 2,
    parameter int NUM_ENG       = 4,
    parameter int PACKET_LENGTH = 2,
    parameter int STRIPE_W      = 16,
    parameter int BM_ADDR_W     = $clog2(M_MAX)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    input  logic [$clog2(K_MAX+1)-1:0]   k_cfg,
    input  logic [$clog2(M_MAX+1)-1:0]   m_cfg,
    input  logic [STRIPE_W-1:0]          num_stripes,
    output logic                         busy,
    output logic                         done,
    output logic                         cfg_err,
    output logic [STRIPE_W-1:0]          stripe_cnt,
    output logic                         bm_rd_rq,
    output logic [BM_ADDR_W-1:0]         bm_rd_addr,
    input  logic                         bm_rd_val,
    output logic                         eng_bm_load,
    output logic [$clog2(NUM_ENG)-1:0]   eng_bm_slot,
    output logic [NUM_ENG-1:0]           eng_row_mask,
    output logic                         eng_rst,
    input  logic                         inbuf_empty,
    output logic                         inbuf_rd_rq,
    output logic                         inbuf_rewind,
    output logic                         inbuf_release,
    input  logic                         eng_in_rdy,
    output logic                         eng_in_val,
    input  logic                         eng_out_val,
    output logic                         eng_out_rdy,
    input  logic                         outbuf_full,
    output logic                         outbuf_wr_en
);
    localparam int KW  = $clog2(K_MAX+1);
    localparam int MW  = $clog2(M_MAX+1);
    localparam int SLW = $clog2(NUM_ENG);
    localparam int WW  = $clog2(K_MAX*PACKET_LENGTH+1);
    localparam int RW  = MW + 1;  // one spare bit so row arithmetic past m never wraps

    localparam logic [KW-1:0]  K_LO      = KW'(K_MIN);
    localparam logic [KW-1:0]  K_HI      = KW'(K_MAX);
    localparam logic [MW-1:0]  M_LO      = MW'(M_MIN);
    localparam logic [MW-1:0]  M_HI      = MW'(M_MAX);
    localparam logic [SLW-1:0] LAST_SLOT = SLW'(NUM_ENG-1);
    localparam logic [RW-1:0]  ENG_STEP  = RW'(NUM_ENG);
    localparam logic [WW-1:0]  PKT       = WW'(PACKET_LENGTH);

    typedef enum logic [2:0] {IDLE, CHECK, FETCH, BM_WAIT, FEED, WRITE, NEXT} state_t;

    state_t              state, state_nxt;
    logic [KW-1:0]       k_q, k_nxt;
    logic [MW-1:0]       m_q, m_nxt;
    logic [STRIPE_W-1:0] ns_q, ns_nxt, stripe_nxt;
    // The pass is held as its first row (pass*NUM_ENG), which is what every
    // consumer needs.
    logic [RW-1:0]       pass_base, base_nxt;
    logic [SLW-1:0]      slot, slot_nxt;
    logic [WW-1:0]       pop_cnt, pop_nxt, wr_cnt, wr_nxt;
    logic [NUM_ENG-1:0]  mask_nxt, mask_calc;
    logic [BM_ADDR_W-1:0] addr_nxt;
    logic                rq_nxt, eng_rst_nxt, rewind_nxt, release_nxt, done_nxt, cfg_err_nxt;
    logic [RW-1:0]       row;
    logic [WW-1:0]       feed_total, wr_total;
    logic                last_stripe;

    // Parity words drained per pass: one packet per active slot.
    function automatic logic [WW-1:0] write_words(input logic [NUM_ENG-1:0] mask);
        logic [WW-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_ENG; i++) n = n + WW'(mask[i]);
        return n * PKT;
    endfunction

    assign busy        = (state != IDLE);
    assign eng_bm_slot = slot;
    assign row         = pass_base + RW'(slot);
    assign feed_total  = WW'(k_q) * PKT;
    assign wr_total    = write_words(eng_row_mask);
    assign last_stripe = ((STRIPE_W+1)'(stripe_cnt) + (STRIPE_W+1)'(1)) == {1'b0, ns_q};

    always_comb begin
        mask_calc = '0;
        for (int i = 0; i < NUM_ENG; i++)
            mask_calc[i] = (pass_base + RW'(i)) < {1'b0, m_q};
    end

    always_comb begin
        state_nxt    = state;
        k_nxt        = k_q;
        m_nxt        = m_q;
        ns_nxt       = ns_q;
        base_nxt     = pass_base;
        slot_nxt     = slot;
        pop_nxt      = pop_cnt;
        wr_nxt       = wr_cnt;
        stripe_nxt   = stripe_cnt;
        mask_nxt     = eng_row_mask;
        addr_nxt     = bm_rd_addr;
        rq_nxt       = 1'b0;
        eng_rst_nxt  = 1'b0;
        rewind_nxt   = 1'b0;
        release_nxt  = 1'b0;
        done_nxt     = 1'b0;
        cfg_err_nxt  = 1'b0;
        eng_bm_load  = 1'b0;
        inbuf_rd_rq  = 1'b0;
        eng_out_rdy  = 1'b0;
        outbuf_wr_en = 1'b0;
        // Abort overrides everything, including a row arriving this cycle.
        if (abort && state != IDLE) begin
            state_nxt   = IDLE;
            eng_rst_nxt = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        k_nxt      = k_cfg;
                        m_nxt      = m_cfg;
                        ns_nxt     = num_stripes;
                        stripe_nxt = '0;
                        base_nxt   = '0;
                        slot_nxt   = '0;
                        state_nxt  = CHECK;
                    end
                end
                CHECK: begin
                    if (k_q < K_LO || k_q > K_HI || m_q < M_LO || m_q > M_HI) begin
                        cfg_err_nxt = 1'b1;
                        state_nxt   = IDLE;
                    end else if (ns_q == '0) begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        eng_rst_nxt = 1'b1;
                        state_nxt   = FETCH;
                    end
                end
                FETCH: begin
                    rq_nxt   = 1'b1;
                    addr_nxt = BM_ADDR_W'(row);
                    if (slot == '0) mask_nxt = mask_calc;
                    state_nxt = BM_WAIT;
                end
                BM_WAIT: begin
                    eng_bm_load = bm_rd_val;
                    if (bm_rd_val) begin
                        slot_nxt = slot + SLW'(1);
                        if (slot == LAST_SLOT || (row + RW'(1)) == {1'b0, m_q}) begin
                            pop_nxt   = '0;
                            state_nxt = FEED;
                        end else begin
                            state_nxt = FETCH;
                        end
                    end
                end
                FEED: begin
                    // FIFO read latency is one cycle, so the pass ends only
                    // once the word from the last pop has been presented.
                    inbuf_rd_rq = !inbuf_empty && eng_in_rdy && (pop_cnt != feed_total);
                    if (inbuf_rd_rq) pop_nxt = pop_cnt + WW'(1);
                    if (pop_cnt == feed_total && eng_in_val) begin
                        wr_nxt    = '0;
                        state_nxt = WRITE;
                    end
                end
                WRITE: begin
                    if (wr_cnt != wr_total) begin
                        eng_out_rdy  = !outbuf_full;
                        outbuf_wr_en = eng_out_val && !outbuf_full;
                        if (outbuf_wr_en) begin
                            wr_nxt = wr_cnt + WW'(1);
                            if ((wr_cnt + WW'(1)) == wr_total) state_nxt = NEXT;
                        end
                    end
                end
                NEXT: begin
                    slot_nxt = '0;
                    if ((pass_base + ENG_STEP) < {1'b0, m_q}) begin
                        rewind_nxt  = 1'b1;
                        base_nxt    = pass_base + ENG_STEP;
                        eng_rst_nxt = 1'b1;
                        state_nxt   = FETCH;
                    end else begin
                        release_nxt = 1'b1;
                        stripe_nxt  = stripe_cnt + STRIPE_W'(1);
                        base_nxt    = '0;
                        if (last_stripe) begin
                            done_nxt  = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            eng_rst_nxt = 1'b1;
                            state_nxt   = FETCH;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            k_q           <= '0;
            m_q           <= '0;
            ns_q          <= '0;
            pass_base     <= '0;
            slot          <= '0;
            pop_cnt       <= '0;
            wr_cnt        <= '0;
            stripe_cnt    <= '0;
            eng_row_mask  <= '0;
            bm_rd_addr    <= '0;
            bm_rd_rq      <= 1'b0;
            eng_rst       <= 1'b0;
            inbuf_rewind  <= 1'b0;
            inbuf_release <= 1'b0;
            done          <= 1'b0;
            cfg_err       <= 1'b0;
            eng_in_val    <= 1'b0;
        end else begin
            state         <= state_nxt;
            k_q           <= k_nxt;
            m_q           <= m_nxt;
            ns_q          <= ns_nxt;
            pass_base     <= base_nxt;
            slot          <= slot_nxt;
            pop_cnt       <= pop_nxt;
            wr_cnt        <= wr_nxt;
            stripe_cnt    <= stripe_nxt;
            eng_row_mask  <= mask_nxt;
            bm_rd_addr    <= addr_nxt;
            bm_rd_rq      <= rq_nxt;
            eng_rst       <= eng_rst_nxt;
            inbuf_rewind  <= rewind_nxt;
            inbuf_release <= release_nxt;
            done          <= done_nxt;
            cfg_err       <= cfg_err_nxt;
            eng_in_val    <= inbuf_rd_rq;
        end
    end
endmodule

// File: tb/tb_ec_stripe_sequencer.sv
// Directed testbench for ec_stripe_sequencer (default parameters).
// A small responder returns bitmatrix rows one cycle after each request.
// Monitors on the falling edge count every strobe.
module tb_ec_stripe_sequencer;
    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic [7:0]  k_cfg, m_cfg;
    logic [15:0] num_stripes;
    logic        busy, done, cfg_err;
    logic [15:0] stripe_cnt;
    logic        bm_rd_rq;
    logic [6:0]  bm_rd_addr;
    logic        bm_rd_val;
    logic        eng_bm_load;
    logic [1:0]  eng_bm_slot;
    logic [3:0]  eng_row_mask;
    logic        eng_rst, inbuf_empty, inbuf_rd_rq, inbuf_rewind, inbuf_release;
    logic        eng_in_rdy, eng_in_val, eng_out_val, eng_out_rdy, outbuf_full, outbuf_wr_en;

    ec_stripe_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .k_cfg(k_cfg), .m_cfg(m_cfg), .num_stripes(num_stripes),
        .busy(busy), .done(done), .cfg_err(cfg_err), .stripe_cnt(stripe_cnt),
        .bm_rd_rq(bm_rd_rq), .bm_rd_addr(bm_rd_addr), .bm_rd_val(bm_rd_val),
        .eng_bm_load(eng_bm_load), .eng_bm_slot(eng_bm_slot), .eng_row_mask(eng_row_mask),
        .eng_rst(eng_rst), .inbuf_empty(inbuf_empty), .inbuf_rd_rq(inbuf_rd_rq),
        .inbuf_rewind(inbuf_rewind), .inbuf_release(inbuf_release),
        .eng_in_rdy(eng_in_rdy), .eng_in_val(eng_in_val),
        .eng_out_val(eng_out_val), .eng_out_rdy(eng_out_rdy),
        .outbuf_full(outbuf_full), .outbuf_wr_en(outbuf_wr_en)
    );

    always #5 clk = ~clk;

    logic [40:0] all_outs;
    assign all_outs = {busy, done, cfg_err, stripe_cnt, bm_rd_rq, bm_rd_addr, eng_bm_load,
                       eng_bm_slot, eng_row_mask, eng_rst, inbuf_rd_rq, inbuf_rewind,
                       inbuf_release, eng_in_val, eng_out_rdy, outbuf_wr_en};

    int n_chk = 0, n_fail = 0;
    int n_rd, n_pop, n_inval, n_wr, n_wr_full, n_rew, n_rel, n_done, n_cfgerr, n_erst, n_load, n_mask;
    logic [6:0] rd_addr [0:15];
    logic [3:0] masks   [0:7];
    logic bm_pend = 1'b0;
    logic rnd_en  = 1'b0;

    always @(negedge clk) begin
        if (bm_rd_rq) begin
            if (n_rd < 16) rd_addr[n_rd] = bm_rd_addr;
            n_rd++;
        end
        bm_pend = bm_rd_rq;
        if (inbuf_rd_rq) n_pop++;
        if (eng_in_val) n_inval++;
        if (outbuf_wr_en) n_wr++;
        if (outbuf_wr_en && outbuf_full) n_wr_full++;
        if (inbuf_rewind) n_rew++;
        if (inbuf_release) n_rel++;
        if (done) n_done++;
        if (cfg_err) n_cfgerr++;
        if (eng_rst) n_erst++;
        if (eng_bm_load) begin
            n_load++;
            if (eng_bm_slot == 2'd0) begin
                if (n_mask < 8) masks[n_mask] = eng_row_mask;
                n_mask++;
            end
        end
    end

    // Row memory responder (latency 1) and optional random back-pressure.
    always @(posedge clk) begin
        #1;
        bm_rd_val = bm_pend;
        if (rnd_en) begin
            inbuf_empty = 1'($urandom_range(0, 1));
            eng_in_rdy  = 1'($urandom_range(0, 1));
            outbuf_full = 1'($urandom_range(0, 1));
            eng_out_val = 1'($urandom_range(0, 1));
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear();
        n_rd = 0; n_pop = 0; n_inval = 0; n_wr = 0; n_wr_full = 0; n_rew = 0; n_rel = 0;
        n_done = 0; n_cfgerr = 0; n_erst = 0; n_load = 0; n_mask = 0;
    endtask

    // Returns just after the edge that samples start.
    task automatic start_job(input logic [7:0] k, input logic [7:0] m, input logic [15:0] ns);
        @(posedge clk); #1;
        k_cfg = k; m_cfg = m; num_stripes = ns; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int budget);
        int snap;
        int cyc;
        snap = n_done + n_cfgerr;
        cyc  = 0;
        while (n_done + n_cfgerr == snap && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        check(tag, 64'(n_done + n_cfgerr != snap), 64'd1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; k_cfg = '0; m_cfg = '0; num_stripes = '0;
        bm_rd_val = 1'b0; inbuf_empty = 1'b0; eng_in_rdy = 1'b1; eng_out_val = 1'b1; outbuf_full = 1'b0;
        clear();
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 64'(all_outs), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_reset", 64'(all_outs), 64'd0);

        // Single pass: k=4, m=4, one stripe.
        clear();
        start_job(8'd4, 8'd4, 16'd1);
        check("t1_busy_next_edge", 64'(busy), 64'd1);
        wait_end("t1_finished", 400);
        check("t1_bm_reads", 64'(n_rd), 64'd4);
        check("t1_bm_addrs", 64'({rd_addr[0], rd_addr[1], rd_addr[2], rd_addr[3]}),
              64'({7'd0, 7'd1, 7'd2, 7'd3}));
        check("t1_loads", 64'(n_load), 64'd4);
        check("t1_mask", 64'(masks[0]), 64'hF);
        check("t1_pops", 64'(n_pop), 64'd8);
        check("t1_in_val", 64'(n_inval), 64'd8);
        check("t1_writes", 64'(n_wr), 64'd8);
        check("t1_rewinds", 64'(n_rew), 64'd0);
        check("t1_releases", 64'(n_rel), 64'd1);
        check("t1_eng_rst", 64'(n_erst), 64'd1);
        check("t1_stripe_cnt", 64'(stripe_cnt), 64'd1);
        @(negedge clk);
        check("t1_done_one_cycle", 64'({done, busy}), 64'd0);
        check("t1_done_count", 64'(n_done), 64'd1);

        // Two passes per stripe: k=3, m=6, two stripes.
        clear();
        start_job(8'd3, 8'd6, 16'd2);
        wait_end("t2_finished", 800);
        check("t2_bm_reads", 64'(n_rd), 64'd12);
        for (int i = 0; i < 12; i++)
            check($sformatf("t2_bm_addr%0d", i), 64'(rd_addr[i]), 64'(i % 6));
        check("t2_mask_count", 64'(n_mask), 64'd4);
        check("t2_masks", 64'({masks[0], masks[1], masks[2], masks[3]}), 64'hF3F3);
        check("t2_pops", 64'(n_pop), 64'd24);
        check("t2_writes", 64'(n_wr), 64'd24);
        check("t2_rewinds", 64'(n_rew), 64'd2);
        check("t2_releases", 64'(n_rel), 64'd2);
        check("t2_eng_rst", 64'(n_erst), 64'd4);
        check("t2_done", 64'(n_done), 64'd1);
        check("t2_stripe_cnt", 64'(stripe_cnt), 64'd2);

        // Illegal k: cfg_err two cycles after start, nothing else.
        clear();
        start_job(8'd1, 8'd4, 16'd1);
        @(negedge clk);
        check("t3k_busy", 64'(busy), 64'd1);
        check("t3k_no_err_yet", 64'(cfg_err), 64'd0);
        @(negedge clk);
        check("t3k_cfg_err", 64'({cfg_err, busy}), 64'b10);
        @(negedge clk);
        check("t3k_err_one_cycle", 64'(cfg_err), 64'd0);
        check("t3k_no_reads", 64'(n_rd), 64'd0);

        // Illegal m = 129.
        clear();
        start_job(8'd4, 8'd129, 16'd1);
        repeat (3) @(negedge clk);
        check("t3m_cfg_err", 64'(n_cfgerr), 64'd1);
        check("t3m_quiet", 64'({n_rd, n_done, n_erst}), 64'd0);

        // Zero stripes: done only.
        clear();
        start_job(8'd4, 8'd4, 16'd0);
        @(negedge clk);
        check("t3z_no_done_yet", 64'(done), 64'd0);
        @(negedge clk);
        check("t3z_done", 64'({done, busy}), 64'b10);
        repeat (2) @(negedge clk);
        check("t3z_quiet", 64'({n_rd, n_erst, n_rel, n_cfgerr, n_pop}), 64'd0);
        check("t3z_done_count", 64'(n_done), 64'd1);

        // Random back-pressure at k=2, m=2.
        clear();
        rnd_en = 1'b1;
        start_job(8'd2, 8'd2, 16'd1);
        wait_end("t4_finished", 3000);
        rnd_en = 1'b0;
        inbuf_empty = 1'b0; eng_in_rdy = 1'b1; outbuf_full = 1'b0; eng_out_val = 1'b1;
        check("t4_pops", 64'(n_pop), 64'd4);
        check("t4_in_val", 64'(n_inval), 64'd4);
        check("t4_writes", 64'(n_wr), 64'd4);
        check("t4_write_while_full", 64'(n_wr_full), 64'd0);
        check("t4_mask", 64'(masks[0]), 64'h3);

        // Abort in the middle of FEED.
        clear();
        start_job(8'd4, 8'd4, 16'd1);
        begin
            int cyc;
            int pops_at;
            int erst_at;
            cyc = 0;
            while (n_pop < 3 && cyc < 200) begin
                @(negedge clk);
                cyc++;
            end
            check("t5_reached_feed", 64'(n_pop >= 3), 64'd1);
            @(posedge clk); #1;
            abort = 1'b1;
            erst_at = n_erst;
            @(posedge clk); #1;
            abort = 1'b0;
            check("t5_abort_idle", 64'({busy, eng_rst, inbuf_rd_rq, bm_rd_rq}), 64'b0100);
            pops_at = n_pop;
            repeat (5) @(negedge clk);
            check("t5_no_more_pops", 64'(n_pop), 64'(pops_at));
            check("t5_one_eng_rst", 64'(n_erst - erst_at), 64'd1);
            check("t5_no_done_release", 64'({n_done, n_rel}), 64'd0);
        end
        clear();
        start_job(8'd4, 8'd4, 16'd1);
        wait_end("t5_rerun_finished", 400);
        check("t5_rerun_writes", 64'(n_wr), 64'd8);
        check("t5_rerun_stripe_cnt", 64'(stripe_cnt), 64'd1);

        // Asynchronous reset in the middle of WRITE.
        clear();
        start_job(8'd2, 8'd2, 16'd1);
        begin
            int cyc;
            cyc = 0;
            while (n_wr < 2 && cyc < 200) begin
                @(negedge clk);
                cyc++;
            end
            check("t6_reached_write", 64'({busy, eng_out_rdy}), 64'b11);
            rst = 1'b1;
            #1;
            check("t6_async_clear", 64'(all_outs), 64'd0);
            @(posedge clk); #1;
            check("t6_held_clear", 64'(all_outs), 64'd0);
            rst = 1'b0;
        end
        clear();
        start_job(8'd4, 8'd4, 16'd1);
        wait_end("t6_clean_finished", 400);
        check("t6_clean_reads", 64'(n_rd), 64'd4);
        check("t6_clean_writes", 64'(n_wr), 64'd8);
        check("t6_clean_release", 64'(n_rel), 64'd1);
        check("t6_clean_stripe_cnt", 64'(stripe_cnt), 64'd1);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
